// File: rtl/tickgen_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Config select encoding and the default period helper.
package tickgen_pkg;

  typedef enum logic [1:0] {
    CFG_PERIOD = 2'd0,
    CFG_WIDTH  = 2'd1,
    CFG_PHASE  = 2'd2,
    CFG_RSVD   = 2'd3
  } cfg_sel_t;

  localparam int DEF_CLK_HZ = 12000000;

  function automatic int def_period(input int clk_hz);
    return clk_hz - 1;
  endfunction

endpackage

// File: rtl/tickgen_chan.sv
// One tick/pulse channel: counter, shadow/active config,
// width counter and registered tick/pulse outputs.
module tickgen_chan
  import tickgen_pkg::*;
#(
  parameter int              CW      = 24,
  parameter logic [CW-1:0]   RST_PER = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr_per,
  input  logic          wr_wid,
  input  logic          wr_pha,
  input  logic [CW-1:0] wdata,
  output logic          tick,
  output logic          pulse,
  output logic          half_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] per_sh_q, per_sh_d;
  logic [CW-1:0] wid_sh_q, wid_sh_d;
  logic [CW-1:0] pha_sh_q, pha_sh_d;
  logic [CW-1:0] per_act_q, per_act_d;
  logic [CW-1:0] wid_act_q, wid_act_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] pha_cl;
  logic          tick_q, tick_d;
  logic          pulse_q, pulse_d;
  logic          wrap;

  always_comb begin
    per_sh_d  = wr_per ? wdata : per_sh_q;
    wid_sh_d  = wr_wid ? wdata : wid_sh_q;
    pha_sh_d  = wr_pha ? wdata : pha_sh_q;
    wrap      = en && (cnt_q == per_act_q);
    tick_d    = wrap;
    per_act_d = per_act_q;
    wid_act_d = wid_act_q;
    if (wrap) begin
      per_act_d = per_sh_q;
      wid_act_d = wid_sh_q;
    end
    // clamp against the period that will be live after this edge
    pha_cl = (pha_sh_q > per_act_d) ? per_act_d : pha_sh_q;
    if (!en)
      cnt_d = '0;
    else if (sync)
      cnt_d = pha_cl;
    else if (wrap)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
    if (!en)
      wcnt_d = '0;
    else if (wrap)
      wcnt_d = wid_act_d;
    else if (wcnt_q != '0)
      wcnt_d = wcnt_q - 1'b1;
    else
      wcnt_d = '0;
    pulse_d = (wcnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      per_sh_q  <= RST_PER;
      wid_sh_q  <= CW'(1);
      pha_sh_q  <= '0;
      per_act_q <= RST_PER;
      wid_act_q <= CW'(1);
      wcnt_q    <= '0;
      tick_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      wid_sh_q  <= wid_sh_d;
      pha_sh_q  <= pha_sh_d;
      per_act_q <= per_act_d;
      wid_act_q <= wid_act_d;
      wcnt_q    <= wcnt_d;
      tick_q    <= tick_d;
      pulse_q   <= pulse_d;
    end
  end

  assign tick   = tick_q;
  assign pulse  = pulse_q;
  assign half_o = (cnt_q > (per_act_q >> 1));

endmodule

// File: rtl/tickgen_multi.sv
// Multi-channel programmable tick/pulse generator top:
// config decode, ack, sync fan-out and ch0 heartbeat LED.
module tickgen_multi
  import tickgen_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int NCH    = 4,
  parameter int CW     = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [2:0]     cfg_ch,
  input  logic [1:0]     cfg_sel,
  input  logic [CW-1:0]  cfg_data,
  output logic           cfg_ack,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pulse,
  output logic           led
);

  localparam logic [CW-1:0]  RST_PER  = CW'(def_period(CLK_HZ));
  localparam logic [NCH-1:0] LED_MASK = NCH'(1);

  cfg_sel_t       sel;
  logic [NCH-1:0] wr_per, wr_wid, wr_pha;
  logic [NCH-1:0] half;
  logic           ack_q, ack_d;
  logic           led_q, led_d;

  assign sel = cfg_sel_t'(cfg_sel);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_per[i] = cfg_we && (cfg_ch == 3'(i)) && (sel == CFG_PERIOD);
    assign wr_wid[i] = cfg_we && (cfg_ch == 3'(i)) && (sel == CFG_WIDTH);
    assign wr_pha[i] = cfg_we && (cfg_ch == 3'(i)) && (sel == CFG_PHASE);

    tickgen_chan #(
      .CW      (CW),
      .RST_PER (RST_PER)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .sync   (sync),
      .wr_per (wr_per[i]),
      .wr_wid (wr_wid[i]),
      .wr_pha (wr_pha[i]),
      .wdata  (cfg_data),
      .tick   (tick[i]),
      .pulse  (pulse[i]),
      .half_o (half[i])
    );
  end

  always_comb begin
    ack_d = cfg_we;
    led_d = en && ((half & LED_MASK) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      led_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      led_q <= led_d;
    end
  end

  assign cfg_ack = ack_q;
  assign led     = led_q;

endmodule

// File: tb/tb_tickgen_multi.sv
// Directed bench for tickgen_multi (CLK_HZ=100, NCH=2, CW=8).
// Inputs driven and outputs sampled 1 time unit after posedge.
module tb_tickgen_multi;

  logic       clk = 1'b0;
  logic       rst, en, sync, cfg_we;
  logic [2:0] cfg_ch;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       cfg_ack, led;
  logic [1:0] tick, pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tickgen_multi #(.CLK_HZ(100), .NCH(2), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .cfg_ack  (cfg_ack),
    .tick     (tick),
    .pulse    (pulse),
    .led      (led)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input int ch, input int maxc, output int n);
    n = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk);
      #1;
      if (tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic cfg_wr(input string tag, input int ch, input int s, input int d);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_sel  = 2'(s);
    cfg_data = 8'(d);
    step(1);
    cfg_we   = 1'b0;
    chk(tag, int'(cfg_ack), 1);
  endtask

  initial begin
    int n, pc, lc, t0, t1;
    rst = 1'b1; en = 1'b1; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    step(3);
    chk("rst_tick",  int'(tick), 0);
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_led",   int'(led), 0);
    chk("rst_ack",   int'(cfg_ack), 0);

    // 1: default 100-cycle period on both channels
    rst = 1'b0;
    wait_tick(0, 150, n);
    chk("t1_first", n, 100);
    chk("t1_tick_both", int'(tick), 3);
    chk("t1_pulse_both", int'(pulse), 3);
    lc = 0;
    repeat (100) begin
      step(1);
      lc += int'(led);
    end
    chk("t1_led_cnt", lc, 50);
    chk("t1_period", int'(tick), 3);

    // 2: ch1 period change mid-period, no runt
    step(40);
    cfg_wr("t2_ack", 1, 0, 9);
    step(1);
    chk("t2_ack_drop", int'(cfg_ack), 0);
    wait_tick(1, 150, n);
    chk("t2_last_long", n, 58);
    wait_tick(1, 50, n);
    chk("t2_short1", n, 10);
    wait_tick(1, 50, n);
    chk("t2_short2", n, 10);

    // 3: ch0 width programming
    cfg_wr("t3_ack_p", 0, 0, 9);
    cfg_wr("t3_ack_w", 0, 1, 3);
    wait_tick(0, 200, n);
    chk("t3_applied", int'(n > 0), 1);
    pc = int'(pulse[0]);
    repeat (9) begin
      step(1);
      pc += int'(pulse[0]);
    end
    chk("t3_w3", pc, 3);
    wait_tick(0, 20, n);
    chk("t3_p10", n, 1);
    cfg_wr("t3_ack_w0", 0, 1, 0);
    wait_tick(0, 20, n);
    chk("t3_p_w0", n, 9);
    pc = int'(pulse[0]);
    repeat (9) begin
      step(1);
      pc += int'(pulse[0]);
    end
    chk("t3_w0", pc, 0);
    wait_tick(0, 20, n);
    chk("t3_p10b", n, 1);
    cfg_wr("t3_ack_w15", 0, 1, 15);
    wait_tick(0, 20, n);
    pc = 0;
    repeat (20) begin
      step(1);
      pc += int'(pulse[0]);
    end
    chk("t3_w15", pc, 20);

    // 4: sync with per-channel phase
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    step(2);
    cfg_wr("t4_ack_ph", 1, 2, 5);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    t0 = 0; t1 = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (tick[0] && t0 == 0) t0 = k;
      if (tick[1] && t1 == 0) t1 = k;
    end
    chk("t4_ch0", t0, 10);
    chk("t4_ch1", t1, 5);
    step(9);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("t4_keep_tick", int'(tick), 1);
    t0 = 0; t1 = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (tick[0] && t0 == 0) t0 = k;
      if (tick[1] && t1 == 0) t1 = k;
    end
    chk("t4_ch0b", t0, 10);
    chk("t4_ch1b", t1, 5);

    // 5: enable drop mid-pulse
    cfg_wr("t5_ack_w3", 0, 1, 3);
    wait_tick(0, 20, n);
    chk("t5_tick", n, 9);
    chk("t5_pulse_on", int'(pulse[0]), 1);
    step(1);
    chk("t5_pulse_mid", int'(pulse[0]), 1);
    en = 1'b0;
    step(1);
    chk("t5_off_tick", int'(tick), 0);
    chk("t5_off_pulse", int'(pulse), 0);
    chk("t5_off_led", int'(led), 0);
    cfg_wr("t5_ack_off", 1, 1, 2);
    step(3);
    chk("t5_hold", int'(tick), 0);
    en = 1'b1;
    wait_tick(0, 20, n);
    chk("t5_restart", n, 10);
    chk("t5_restart_both", int'(tick), 3);
    chk("t5_pulse_a", int'(pulse), 3);
    step(1);
    chk("t5_pulse_b", int'(pulse), 3);
    step(1);
    chk("t5_pulse_c", int'(pulse), 1);

    // 6: reset mid-pulse with a write in flight
    rst = 1'b1;
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_sel = 2'd0; cfg_data = 8'd4;
    step(1);
    rst = 1'b0;
    cfg_we = 1'b0;
    chk("t6_tick", int'(tick), 0);
    chk("t6_pulse", int'(pulse), 0);
    chk("t6_led", int'(led), 0);
    chk("t6_ack", int'(cfg_ack), 0);
    step(1);
    chk("t6_no_ack", int'(cfg_ack), 0);
    wait_tick(0, 250, n);
    chk("t6_default", n, 99);
    chk("t6_both", int'(tick), 3);
    chk("t6_pulse_w1", int'(pulse), 3);
    cfg_wr("t6_ack_ch5", 5, 0, 3);
    chk("t6_w1_end", int'(pulse), 0);
    cfg_wr("t6_ack_rsvd", 0, 3, 3);
    wait_tick(0, 250, n);
    chk("t6_unchanged", n, 98);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
